// File: rtl/loop_fixpoint_iter_if.sv
//------------------------------------------------------------------------------
// Module  : loop_fixpoint_iter_if
// Purpose : Request/result bundle for the bounded fixed-point loop iterator.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface loop_fixpoint_iter_if #(
  parameter int WIDTH    = 2,
  parameter int MAX_ITER = 8,
  parameter int CNT_W    = $clog2(MAX_ITER + 1)
);
  logic             start_i;
  logic [WIDTH-1:0] a_i;
  logic             abort_i;
  logic             ready_o;
  logic             done_o;
  logic [WIDTH-1:0] b_o;
  logic [WIDTH-1:0] c_o;
  logic             converged_o;
  logic [CNT_W-1:0] iters_o;

  modport master (
    output start_i, a_i, abort_i,
    input  ready_o, done_o, b_o, c_o, converged_o, iters_o
  );

  modport slave (
    input  start_i, a_i, abort_i,
    output ready_o, done_o, b_o, c_o, converged_o, iters_o
  );
endinterface

`default_nettype wire

// File: rtl/loop_fixpoint_iter.sv
//------------------------------------------------------------------------------
// Module  : loop_fixpoint_iter
// Purpose : Registered, bounded evaluation of the feedback loop c = b; b = c + STEP.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module loop_fixpoint_iter #(
  parameter int WIDTH    = 2,
  parameter int STEP     = 1,
  parameter int MAX_ITER = 8,
  parameter int CNT_W    = $clog2(MAX_ITER + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  loop_fixpoint_iter_if.slave  bus
);

  localparam logic [WIDTH-1:0] STEP_W    = WIDTH'(STEP);
  localparam logic [CNT_W-1:0] ITER_LIM  = CNT_W'(MAX_ITER);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] c_q;
  logic [CNT_W-1:0] iters_q;
  logic             conv_q;

  logic [WIDTH-1:0] nb;
  logic [CNT_W-1:0] iters_inc;
  logic             fixed_pt;
  logic             at_limit;

  // The next c is the current b, so the fixed point needs nb==b and b==c.
  assign nb        = b_q + STEP_W;
  assign iters_inc = iters_q + CNT_W'(1);
  assign fixed_pt  = (nb == b_q) && (b_q == c_q);
  assign at_limit  = (iters_inc == ITER_LIM);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.start_i) state_nxt = S_ITER;
      S_ITER: begin
        if (bus.abort_i)                state_nxt = S_IDLE;
        else if (fixed_pt || at_limit)  state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      b_q     <= '0;
      c_q     <= '0;
      iters_q <= '0;
      conv_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && bus.start_i) begin
        // Seeding c with ~a guarantees the first evaluation cannot look converged.
        b_q     <= bus.a_i;
        c_q     <= ~bus.a_i;
        iters_q <= '0;
        conv_q  <= 1'b0;
      end else if (state == S_ITER) begin
        b_q     <= nb;
        c_q     <= b_q;
        iters_q <= iters_inc;
        conv_q  <= fixed_pt && !bus.abort_i;
      end
    end
  end

  assign bus.ready_o     = (state == S_IDLE);
  assign bus.done_o      = (state == S_DONE);
  assign bus.b_o         = b_q;
  assign bus.c_o         = c_q;
  assign bus.converged_o = conv_q;
  assign bus.iters_o     = iters_q;

endmodule

`default_nettype wire

// File: tb/tb_loop_fixpoint_iter.sv
//------------------------------------------------------------------------------
// Module  : tb_loop_fixpoint_iter
// Purpose : Bench for loop_fixpoint_iter with STEP = 1, 0 and 4 instances.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_loop_fixpoint_iter;

  localparam int MAX_ITER = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  // Index 0: STEP=1, index 1: STEP=0, index 2: STEP=4 (wraps to 0)
  int         step_tab [3];
  logic [2:0] start_v;
  logic [2:0] abort_v;
  logic [1:0] a_v      [3];
  logic [2:0] ready_v;
  logic [2:0] done_v;
  logic [2:0] conv_v;
  logic [1:0] b_v      [3];
  logic [1:0] c_v      [3];
  logic [3:0] iters_v  [3];

  loop_fixpoint_iter_if #(.WIDTH(2), .MAX_ITER(MAX_ITER)) bus_s1 ();
  loop_fixpoint_iter_if #(.WIDTH(2), .MAX_ITER(MAX_ITER)) bus_s0 ();
  loop_fixpoint_iter_if #(.WIDTH(2), .MAX_ITER(MAX_ITER)) bus_s4 ();

  loop_fixpoint_iter #(.WIDTH(2), .STEP(1), .MAX_ITER(MAX_ITER)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .bus(bus_s1.slave));
  loop_fixpoint_iter #(.WIDTH(2), .STEP(0), .MAX_ITER(MAX_ITER)) dut_s0 (
    .clk(clk), .rst_n(rst_n), .bus(bus_s0.slave));
  loop_fixpoint_iter #(.WIDTH(2), .STEP(4), .MAX_ITER(MAX_ITER)) dut_s4 (
    .clk(clk), .rst_n(rst_n), .bus(bus_s4.slave));

  assign bus_s1.start_i = start_v[0];
  assign bus_s0.start_i = start_v[1];
  assign bus_s4.start_i = start_v[2];
  assign bus_s1.abort_i = abort_v[0];
  assign bus_s0.abort_i = abort_v[1];
  assign bus_s4.abort_i = abort_v[2];
  assign bus_s1.a_i     = a_v[0];
  assign bus_s0.a_i     = a_v[1];
  assign bus_s4.a_i     = a_v[2];

  assign ready_v = {bus_s4.ready_o, bus_s0.ready_o, bus_s1.ready_o};
  assign done_v  = {bus_s4.done_o, bus_s0.done_o, bus_s1.done_o};
  assign conv_v  = {bus_s4.converged_o, bus_s0.converged_o, bus_s1.converged_o};
  assign b_v[0] = bus_s1.b_o;      assign b_v[1] = bus_s0.b_o;      assign b_v[2] = bus_s4.b_o;
  assign c_v[0] = bus_s1.c_o;      assign c_v[1] = bus_s0.c_o;      assign c_v[2] = bus_s4.c_o;
  assign iters_v[0] = bus_s1.iters_o;
  assign iters_v[1] = bus_s0.iters_o;
  assign iters_v[2] = bus_s4.iters_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: run the source loop directly, stopping at abort, fixed point or limit.
  function automatic void model(input int step, input logic [1:0] a, input int stop,
                                output int k, output logic [1:0] b, output logic [1:0] c,
                                output logic conv, output bit aborted);
    logic [1:0] s;
    logic [1:0] nb;
    logic [1:0] nc;
    bit         fin;
    s = 2'(step % 4);
    b = a;
    c = ~a;
    k = 0;
    conv = 1'b0;
    aborted = 1'b0;
    fin = 1'b0;
    while (!fin) begin
      nc = b;
      nb = b + s;
      k++;
      if (stop == k) begin
        aborted = 1'b1;
        fin = 1'b1;
      end else if (nb == b && nc == c) begin
        conv = 1'b1;
        fin = 1'b1;
      end else if (k == MAX_ITER) begin
        fin = 1'b1;
      end
      b = nb;
      c = nc;
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    start_v = '0;
    abort_v = '0;
    for (int i = 0; i < 3; i++) a_v[i] = 2'(i);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (ready_v[i] !== 1'b1) begin n_fail++; $display("FAIL reset_ready[%0d]: got %b expected 1", i, ready_v[i]); end
      n_checks++;
      if (done_v[i] !== 1'b0) begin n_fail++; $display("FAIL reset_done[%0d]: got %b expected 0", i, done_v[i]); end
      n_checks++;
      if (b_v[i] !== 2'b00 || c_v[i] !== 2'b00) begin
        n_fail++; $display("FAIL reset_bc[%0d]: got b=%b c=%b expected 00/00", i, b_v[i], c_v[i]);
      end
      n_checks++;
      if (iters_v[i] !== 4'd0 || conv_v[i] !== 1'b0) begin
        n_fail++; $display("FAIL reset_iters_conv[%0d]: got iters=%0d conv=%b expected 0/0", i, iters_v[i], conv_v[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One request on instance idx; abort_at/restart_at are cycles after accept (0 = never).
  task automatic run_one(input int idx, input logic [1:0] a, input int abort_at,
                         input int restart_at, input bit abort_idle);
    int         k;
    int         end_cyc;
    logic [1:0] eb;
    logic [1:0] ec;
    logic       econv;
    bit         aborted;
    model(step_tab[idx], a, abort_at, k, eb, ec, econv, aborted);
    end_cyc = aborted ? abort_at + 1 : k + 1;
    n_checks++;
    if (ready_v[idx] !== 1'b1) begin n_fail++; $display("FAIL pre_ready[%0d]: got %b expected 1", idx, ready_v[idx]); end
    start_v[idx] = 1'b1;
    a_v[idx] = a;
    abort_v[idx] = abort_idle;
    for (int cyc = 1; cyc <= end_cyc; cyc++) begin
      @(posedge clk);
      #1;
      start_v[idx] = (cyc == restart_at);
      abort_v[idx] = (cyc == abort_at);
      n_checks++;
      if (done_v[idx] !== (!aborted && cyc == k + 1)) begin
        n_fail++; $display("FAIL done_pulse[%0d] cyc %0d: got %b expected %b", idx, cyc, done_v[idx], !aborted && cyc == k + 1);
      end
      n_checks++;
      if (ready_v[idx] !== (aborted && cyc == end_cyc)) begin
        n_fail++; $display("FAIL ready[%0d] cyc %0d: got %b expected %b", idx, cyc, ready_v[idx], aborted && cyc == end_cyc);
      end
    end
    start_v[idx] = 1'b0;
    abort_v[idx] = 1'b0;
    n_checks++;
    if (b_v[idx] !== eb || c_v[idx] !== ec) begin
      n_fail++; $display("FAIL result_bc[%0d] a=%b: got b=%b c=%b expected b=%b c=%b", idx, a, b_v[idx], c_v[idx], eb, ec);
    end
    n_checks++;
    if (iters_v[idx] !== 4'(aborted ? abort_at : k) || conv_v[idx] !== econv) begin
      n_fail++; $display("FAIL result_iters[%0d] a=%b: got iters=%0d conv=%b expected iters=%0d conv=%b",
                         idx, a, iters_v[idx], conv_v[idx], aborted ? abort_at : k, econv);
    end
    if (!aborted) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (ready_v[idx] !== 1'b1 || done_v[idx] !== 1'b0 || b_v[idx] !== eb || c_v[idx] !== ec) begin
        n_fail++; $display("FAIL post_done_hold[%0d]: got ready=%b done=%b b=%b c=%b expected 1/0/%b/%b",
                           idx, ready_v[idx], done_v[idx], b_v[idx], c_v[idx], eb, ec);
      end
    end
  endtask

  task automatic test_reset_mid_iter();
    start_v[0] = 1'b1;
    a_v[0] = 2'b10;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ready_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
      n_fail++; $display("FAIL midreset_ctrl: got ready=%b done=%b expected 1/0", ready_v[0], done_v[0]);
    end
    n_checks++;
    if (b_v[0] !== 2'b00 || c_v[0] !== 2'b00 || iters_v[0] !== 4'd0 || conv_v[0] !== 1'b0) begin
      n_fail++; $display("FAIL midreset_data: got b=%b c=%b iters=%0d conv=%b expected 0/0/0/0",
                         b_v[0], c_v[0], iters_v[0], conv_v[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_converge_step0();
    run_one(1, 2'b01, 0, 0, 1'b0);
    n_checks++;
    if (b_v[1] !== 2'b01 || c_v[1] !== 2'b01 || conv_v[1] !== 1'b1 || iters_v[1] !== 4'd2) begin
      n_fail++; $display("FAIL step0_fixed: got b=%b c=%b conv=%b iters=%0d expected 01/01/1/2",
                         b_v[1], c_v[1], conv_v[1], iters_v[1]);
    end
  endtask

  task automatic test_limit_step1();
    run_one(0, 2'b01, 0, 0, 1'b0);
    n_checks++;
    if (b_v[0] !== 2'b01 || c_v[0] !== 2'b00 || conv_v[0] !== 1'b0 || iters_v[0] !== 4'd8) begin
      n_fail++; $display("FAIL step1_limit: got b=%b c=%b conv=%b iters=%0d expected 01/00/0/8",
                         b_v[0], c_v[0], conv_v[0], iters_v[0]);
    end
  endtask

  task automatic test_step_wrap();
    run_one(2, 2'b11, 0, 0, 1'b0);
    n_checks++;
    if (b_v[2] !== 2'b11 || c_v[2] !== 2'b11 || conv_v[2] !== 1'b1 || iters_v[2] !== 4'd2) begin
      n_fail++; $display("FAIL step4_wrap: got b=%b c=%b conv=%b iters=%0d expected 11/11/1/2",
                         b_v[2], c_v[2], conv_v[2], iters_v[2]);
    end
  endtask

  task automatic test_abort();
    run_one(0, 2'b01, 3, 2, 1'b0);
    n_checks++;
    if (iters_v[0] !== 4'd3 || conv_v[0] !== 1'b0) begin
      n_fail++; $display("FAIL abort_partial: got iters=%0d conv=%b expected 3/0", iters_v[0], conv_v[0]);
    end
    // Nothing queued from the ignored restart: instance stays idle.
    @(posedge clk);
    #1;
    n_checks++;
    if (ready_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: got ready=%b done=%b expected 1/0", ready_v[0], done_v[0]);
    end
  endtask

  task automatic test_back_to_back();
    start_v[1] = 1'b1;
    a_v[1] = 2'b10;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 8) start_v[1] = 1'b0;
      n_checks++;
      if (done_v[1] !== (cyc == 3 || cyc == 7)) begin
        n_fail++; $display("FAIL b2b_done cyc %0d: got %b expected %b", cyc, done_v[1], cyc == 3 || cyc == 7);
      end
      n_checks++;
      if (ready_v[1] !== (cyc == 4 || cyc == 8 || cyc == 9)) begin
        n_fail++; $display("FAIL b2b_ready cyc %0d: got %b expected %b", cyc, ready_v[1], cyc == 4 || cyc == 8 || cyc == 9);
      end
      if (cyc == 3 || cyc == 7) begin
        n_checks++;
        if (b_v[1] !== 2'b10 || c_v[1] !== 2'b10 || conv_v[1] !== 1'b1 || iters_v[1] !== 4'd2) begin
          n_fail++; $display("FAIL b2b_result cyc %0d: got b=%b c=%b conv=%b iters=%0d expected 10/10/1/2",
                             cyc, b_v[1], c_v[1], conv_v[1], iters_v[1]);
        end
      end
    end
  endtask

  task automatic test_random();
    int idx;
    int abort_at;
    int restart_at;
    for (int n = 0; n < 30; n++) begin
      idx = int'($urandom_range(0, 2));
      abort_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 9)) : 0;
      // Only restart while busy: an in-ITER or DONE start must be dropped.
      restart_at = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 2)) : 0;
      run_one(idx, 2'($urandom), abort_at, restart_at, 1'($urandom));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    step_tab[0] = 1;
    step_tab[1] = 0;
    step_tab[2] = 4;
    test_reset();
    test_converge_step0();
    test_limit_step1();
    test_step_wrap();
    test_abort();
    test_back_to_back();
    test_reset_mid_iter();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
